writeback_stage: RTL and testbench

//  MEM/WB pipeline register and writeback stage of the RV32I core. It captures one retiring

---
 rtl/writeback_stage.sv | 170 +++++++++++++++++
 tb/tb_writeback_stage.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register and writeback stage: captures retiring instructions, waits for and
// extends load data, drives the register-file write port and counts retired instructions.
module writeback_stage #(
    parameter int XLEN      = 32,
    parameter int INSTRET_W = 64
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_mem_valid,
    output logic                 o_mem_ready,
    input  logic [4:0]           i_mem_rd,
    input  logic                 i_mem_reg_write,
    input  logic [1:0]           i_mem_wb_sel,
    input  logic [2:0]           i_mem_funct3,
    input  logic [1:0]           i_mem_addr_lo,
    input  logic [XLEN-1:0]      i_mem_alu_result,
    input  logic [XLEN-1:0]      i_mem_pc_plus4,
    input  logic [XLEN-1:0]      i_mem_csr_rdata,
    input  logic                 i_dmem_rvalid,
    input  logic [XLEN-1:0]      i_dmem_rdata,
    output logic [4:0]           o_rd,
    output logic [XLEN-1:0]      o_rd_din,
    output logic                 o_reg_write,
    output logic [INSTRET_W-1:0] o_instret
);

    // state    | meaning
    // EMPTY    | holds no instruction
    // WAIT_LD  | holds a load, waiting for data-memory response
    // COMMIT   | holds an instruction that writes back this cycle
    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_WAIT_LD = 2'd1,
        ST_COMMIT  = 2'd2
    } state_e;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;

    state_e                 state_q, state_d;
    logic [4:0]             rd_q, rd_d;
    logic                   reg_write_q, reg_write_d;
    logic [1:0]             wb_sel_q, wb_sel_d;
    logic [2:0]             funct3_q, funct3_d;
    logic [1:0]             addr_lo_q, addr_lo_d;
    logic [XLEN-1:0]        alu_result_q, alu_result_d;
    logic [XLEN-1:0]        pc_plus4_q, pc_plus4_d;
    logic [XLEN-1:0]        csr_rdata_q, csr_rdata_d;
    logic [XLEN-1:0]        load_data_q, load_data_d;
    logic [INSTRET_W-1:0]   instret_q, instret_d;

    logic                   capture;
    logic [7:0]             ld_byte;
    logic [15:0]            ld_half;
    logic [XLEN-1:0]        ld_ext;

    assign o_mem_ready = (state_q != ST_WAIT_LD);
    assign capture     = i_mem_valid && o_mem_ready;

    // Byte/half are picked with the captured address; addr_lo[0] is ignored for halves.
    always_comb begin
        ld_byte = 8'h00;
        case (addr_lo_q)
            2'd0:    ld_byte = i_dmem_rdata[7:0];
            2'd1:    ld_byte = i_dmem_rdata[15:8];
            2'd2:    ld_byte = i_dmem_rdata[23:16];
            default: ld_byte = i_dmem_rdata[31:24];
        endcase
        ld_half = addr_lo_q[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];

        ld_ext = i_dmem_rdata;
        case (funct3_q)
            3'b000:  ld_ext = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {{(XLEN-8){1'b0}}, ld_byte};
            3'b101:  ld_ext = {{(XLEN-16){1'b0}}, ld_half};
            default: ld_ext = i_dmem_rdata;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        rd_d         = rd_q;
        reg_write_d  = reg_write_q;
        wb_sel_d     = wb_sel_q;
        funct3_d     = funct3_q;
        addr_lo_d    = addr_lo_q;
        alu_result_d = alu_result_q;
        pc_plus4_d   = pc_plus4_q;
        csr_rdata_d  = csr_rdata_q;
        load_data_d  = load_data_q;
        instret_d    = instret_q;

        if (state_q == ST_COMMIT) begin
            instret_d = instret_q + {{(INSTRET_W-1){1'b0}}, 1'b1};
        end

        case (state_q)
            ST_WAIT_LD: begin
                if (i_dmem_rvalid) begin
                    load_data_d = ld_ext;
                    state_d     = ST_COMMIT;
                end
            end
            default: begin
                if (capture) begin
                    rd_d         = i_mem_rd;
                    reg_write_d  = i_mem_reg_write;
                    wb_sel_d     = i_mem_wb_sel;
                    funct3_d     = i_mem_funct3;
                    addr_lo_d    = i_mem_addr_lo;
                    alu_result_d = i_mem_alu_result;
                    pc_plus4_d   = i_mem_pc_plus4;
                    csr_rdata_d  = i_mem_csr_rdata;
                    state_d      = (i_mem_wb_sel == WB_LOAD) ? ST_WAIT_LD : ST_COMMIT;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_EMPTY;
            rd_q         <= '0;
            reg_write_q  <= 1'b0;
            wb_sel_q     <= '0;
            funct3_q     <= '0;
            addr_lo_q    <= '0;
            alu_result_q <= '0;
            pc_plus4_q   <= '0;
            csr_rdata_q  <= '0;
            load_data_q  <= '0;
            instret_q    <= '0;
        end else begin
            state_q      <= state_d;
            rd_q         <= rd_d;
            reg_write_q  <= reg_write_d;
            wb_sel_q     <= wb_sel_d;
            funct3_q     <= funct3_d;
            addr_lo_q    <= addr_lo_d;
            alu_result_q <= alu_result_d;
            pc_plus4_q   <= pc_plus4_d;
            csr_rdata_q  <= csr_rdata_d;
            load_data_q  <= load_data_d;
            instret_q    <= instret_d;
        end
    end

    always_comb begin
        o_rd        = '0;
        o_rd_din    = '0;
        o_reg_write = 1'b0;
        if (state_q == ST_COMMIT) begin
            o_rd        = rd_q;
            o_reg_write = reg_write_q && (rd_q != 5'd0);
            case (wb_sel_q)
                WB_ALU:  o_rd_din = alu_result_q;
                WB_LOAD: o_rd_din = load_data_q;
                WB_PC4:  o_rd_din = pc_plus4_q;
                default: o_rd_din = csr_rdata_q;
            endcase
        end
    end

    assign o_instret = instret_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_writeback_stage;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_mem_valid = 1'b0;
    logic        o_mem_ready;
    logic [4:0]  i_mem_rd = '0;
    logic        i_mem_reg_write = 1'b0;
    logic [1:0]  i_mem_wb_sel = '0;
    logic [2:0]  i_mem_funct3 = '0;
    logic [1:0]  i_mem_addr_lo = '0;
    logic [31:0] i_mem_alu_result = '0;
    logic [31:0] i_mem_pc_plus4 = '0;
    logic [31:0] i_mem_csr_rdata = '0;
    logic        i_dmem_rvalid = 1'b0;
    logic [31:0] i_dmem_rdata = '0;
    logic [4:0]  o_rd;
    logic [31:0] o_rd_din;
    logic        o_reg_write;
    logic [63:0] o_instret;

    int checks = 0;
    int errors = 0;
    bit started = 0;

    writeback_stage #(.XLEN(32), .INSTRET_W(64)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_mem_valid(i_mem_valid), .o_mem_ready(o_mem_ready),
        .i_mem_rd(i_mem_rd), .i_mem_reg_write(i_mem_reg_write),
        .i_mem_wb_sel(i_mem_wb_sel), .i_mem_funct3(i_mem_funct3),
        .i_mem_addr_lo(i_mem_addr_lo), .i_mem_alu_result(i_mem_alu_result),
        .i_mem_pc_plus4(i_mem_pc_plus4), .i_mem_csr_rdata(i_mem_csr_rdata),
        .i_dmem_rvalid(i_dmem_rvalid), .i_dmem_rdata(i_dmem_rdata),
        .o_rd(o_rd), .o_rd_din(o_rd_din), .o_reg_write(o_reg_write),
        .o_instret(o_instret)
    );

    always #5 i_clk = ~i_clk;

    // Behavioural model: one held instruction, a "waiting for data" flag and a retire count.
    typedef struct {
        logic [4:0]  rd;
        logic        we;
        logic [1:0]  sel;
        logic [2:0]  f3;
        logic [1:0]  alo;
        logic [31:0] alu;
        logic [31:0] pc4;
        logic [31:0] csr;
        logic [31:0] ld;
    } rec_t;

    rec_t        m_rec;
    bit          m_holding = 0;
    bit          m_loading = 0;
    logic [63:0] m_count = '0;

    function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [1:0] alo,
                                               input logic [31:0] rdata);
        logic [31:0] b;
        logic [31:0] h;
        b = (rdata >> (8 * int'(alo))) & 32'hFF;
        h = (rdata >> (16 * int'(alo[1]))) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 32'd128) ? b - 32'd256 : b;
            3'b001:  return (h >= 32'd32768) ? h - 32'd65536 : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return rdata;
        endcase
    endfunction

    always @(posedge i_clk) begin
        if (i_rst) begin
            m_holding = 0;
            m_loading = 0;
            m_count   = '0;
        end else begin
            if (m_holding && !m_loading) m_count = m_count + 64'd1;
            if (m_loading) begin
                if (i_dmem_rvalid) begin
                    m_rec.ld  = load_value(m_rec.f3, m_rec.alo, i_dmem_rdata);
                    m_loading = 0;
                end
            end else if (i_mem_valid) begin
                m_holding   = 1;
                m_loading   = (i_mem_wb_sel == 2'b01);
                m_rec.rd    = i_mem_rd;
                m_rec.we    = i_mem_reg_write;
                m_rec.sel   = i_mem_wb_sel;
                m_rec.f3    = i_mem_funct3;
                m_rec.alo   = i_mem_addr_lo;
                m_rec.alu   = i_mem_alu_result;
                m_rec.pc4   = i_mem_pc_plus4;
                m_rec.csr   = i_mem_csr_rdata;
            end else begin
                m_holding = 0;
            end
        end
    end

    function automatic bit exp_commit();
        return m_holding && !m_loading;
    endfunction

    function automatic logic exp_we();
        return exp_commit() && m_rec.we && (m_rec.rd != 5'd0);
    endfunction

    function automatic logic [4:0] exp_rd();
        return exp_commit() ? m_rec.rd : 5'd0;
    endfunction

    function automatic logic [31:0] exp_din();
        if (!exp_commit()) return 32'd0;
        case (m_rec.sel)
            2'b00:   return m_rec.alu;
            2'b01:   return m_rec.ld;
            2'b10:   return m_rec.pc4;
            default: return m_rec.csr;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge i_clk) begin
        if (started) begin
            chk("ready",     64'(o_mem_ready), 64'(!m_loading));
            chk("reg_write", 64'(o_reg_write), 64'(exp_we()));
            chk("rd",        64'(o_rd),        64'(exp_rd()));
            chk("rd_din",    64'(o_rd_din),    64'(exp_din()));
            chk("instret",   o_instret,        m_count);
        end
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        i_mem_valid   = 1'b0;
        i_dmem_rvalid = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic we, input logic [1:0] sel,
                         input logic [2:0] f3, input logic [1:0] alo, input logic [31:0] alu,
                         input logic [31:0] pc4, input logic [31:0] csr);
        i_mem_valid      = 1'b1;
        i_mem_rd         = rd;
        i_mem_reg_write  = we;
        i_mem_wb_sel     = sel;
        i_mem_funct3     = f3;
        i_mem_addr_lo    = alo;
        i_mem_alu_result = alu;
        i_mem_pc_plus4   = pc4;
        i_mem_csr_rdata  = csr;
    endtask

    task automatic load_case(input string name, input logic [2:0] f3, input logic [1:0] alo,
                             input logic [31:0] rdata, input logic [31:0] lit);
        do_reset();
        issue(5'd9, 1'b1, 2'b01, f3, alo, 32'hDEAD_BEEF, 32'h0, 32'h0);
        step();
        idle();
        i_dmem_rvalid = 1'b1;
        i_dmem_rdata  = rdata;
        step();
        i_dmem_rvalid = 1'b0;
        chk({name, "_we"}, 64'(o_reg_write), 64'd1);
        chk(name, 64'(o_rd_din), 64'(lit));
        chk({name, "_model"}, 64'(exp_din()), 64'(lit));
        step();
    endtask

    initial begin
        step();
        step();
        i_rst   = 1'b0;
        started = 1;

        // Reset values and a single ALU op
        chk("rst_ready", 64'(o_mem_ready), 64'd1);
        chk("rst_instret", o_instret, 64'd0);
        chk("rst_we", 64'(o_reg_write), 64'd0);
        issue(5'd5, 1'b1, 2'b00, 3'b000, 2'd0, 32'h1234, 32'h0, 32'h0);
        step();
        idle();
        chk("alu_we", 64'(o_reg_write), 64'd1);
        chk("alu_rd", 64'(o_rd), 64'd5);
        chk("alu_din", 64'(o_rd_din), 64'h1234);
        step();
        chk("alu_instret", o_instret, 64'd1);

        // Three back-to-back ALU ops
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            issue(5'(i), 1'b1, 2'b00, 3'b000, 2'd0, 32'(i * 16), 32'h0, 32'h0);
            step();
            chk("b2b_we", 64'(o_reg_write), 64'd1);
            chk("b2b_rd", 64'(o_rd), 64'(i));
            chk("b2b_ready", 64'(o_mem_ready), 64'd1);
        end
        idle();
        step();
        chk("b2b_instret", o_instret, 64'd3);

        // lb with late response
        do_reset();
        issue(5'd7, 1'b1, 2'b01, 3'b000, 2'd3, 32'h0, 32'h0, 32'h0);
        step();
        idle();
        for (int i = 0; i < 3; i++) begin
            chk("lb_wait_ready", 64'(o_mem_ready), 64'd0);
            chk("lb_wait_we", 64'(o_reg_write), 64'd0);
            if (i < 2) step();
        end
        i_dmem_rvalid = 1'b1;
        i_dmem_rdata  = 32'h80FF_FF7F;
        step();
        i_dmem_rvalid = 1'b0;
        chk("lb_we", 64'(o_reg_write), 64'd1);
        chk("lb_din", 64'(o_rd_din), 64'hFFFF_FF80);
        step();

        load_case("lhu", 3'b101, 2'd2, 32'h8001_0000, 32'h0000_8001);
        load_case("lh",  3'b001, 2'd2, 32'h8001_0000, 32'hFFFF_8001);
        load_case("lw",  3'b010, 2'd2, 32'h8001_0000, 32'h8001_0000);
        load_case("lbu", 3'b100, 2'd1, 32'h1234_A578, 32'h0000_00A5);

        // rd=0 write suppression, then JAL link value
        do_reset();
        issue(5'd0, 1'b1, 2'b00, 3'b000, 2'd0, 32'hFFFF_FFFF, 32'h0, 32'h0);
        step();
        chk("x0_we", 64'(o_reg_write), 64'd0);
        issue(5'd1, 1'b1, 2'b10, 3'b000, 2'd0, 32'hDEAD, 32'h104, 32'h0);
        step();
        idle();
        chk("x0_instret", o_instret, 64'd1);
        chk("jal_din", 64'(o_rd_din), 64'h104);
        chk("jal_we", 64'(o_reg_write), 64'd1);
        step();

        // Reset abandons a pending load; stale response ignored
        do_reset();
        issue(5'd3, 1'b1, 2'b01, 3'b010, 2'd0, 32'h0, 32'h0, 32'h0);
        step();
        idle();
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        i_dmem_rvalid = 1'b1;
        i_dmem_rdata  = 32'hCAFE_F00D;
        step();
        i_dmem_rvalid = 1'b0;
        chk("abort_we", 64'(o_reg_write), 64'd0);
        chk("abort_ready", 64'(o_mem_ready), 64'd1);
        chk("abort_instret", o_instret, 64'd0);
        step();

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            i_rst            = ($urandom_range(0, 99) == 0);
            i_mem_valid      = ($urandom_range(0, 9) < 7);
            i_mem_rd         = 5'($urandom_range(0, 31));
            i_mem_reg_write  = 1'($urandom_range(0, 1));
            i_mem_wb_sel     = 2'($urandom_range(0, 3));
            i_mem_funct3     = 3'($urandom_range(0, 7));
            i_mem_addr_lo    = 2'($urandom_range(0, 3));
            i_mem_alu_result = $urandom;
            i_mem_pc_plus4   = $urandom;
            i_mem_csr_rdata  = $urandom;
            i_dmem_rvalid    = ($urandom_range(0, 9) < 4);
            i_dmem_rdata     = $urandom;
            step();
        end
        i_rst = 1'b0;
        idle();
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
